lsu: RTL

LSU -- requirements
Module: lsu

---
 rtl/lsu_pkg.sv | 31 +++
 rtl/lsu_align.sv | 64 ++++++
 rtl/lsu.sv | 118 +++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared LSU definitions: FSM states, funct3 access codes and the alignment check.
package lsu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } lsu_state_t;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;
   localparam logic [2:0] SB  = 3'b000;
   localparam logic [2:0] SH  = 3'b001;
   localparam logic [2:0] SW  = 3'b010;

   // Halfwords need addr[0]==0 and words need addr[1:0]==0; byte accesses never fault.
   function automatic logic misaligned(input logic is_store, input logic [2:0] f3,
                                       input logic [1:0] lo);
      logic m;
      m = 1'b0;
      if (f3 == LH || (!is_store && f3 == LHU))
         m = lo[0];
      else if (f3 == LW)
         m = (lo != 2'b00);
      return m;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane handling: load byte/half select with extension, store strobe and replication.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] rdata,
   input  logic [31:0] wdata,
   output logic [31:0] load_ext,
   output logic [3:0]  wstrb,
   output logic [31:0] wdata_rep
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata[7:0];
      case (addr_lo)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
   end

   // Reserved load encodings return zero rather than garbage.
   always_comb begin
      load_ext = 32'd0;
      case (funct3)
         LB:      load_ext = {{24{byte_sel[7]}}, byte_sel};
         LH:      load_ext = {{16{half_sel[15]}}, half_sel};
         LW:      load_ext = rdata;
         LBU:     load_ext = {24'd0, byte_sel};
         LHU:     load_ext = {16'd0, half_sel};
         default: load_ext = 32'd0;
      endcase
   end

   always_comb begin
      wstrb     = 4'b0000;
      wdata_rep = wdata;
      case (funct3)
         SB: begin
            wstrb     = 4'b0001 << addr_lo;
            wdata_rep = {4{wdata[7:0]}};
         end
         SH: begin
            wstrb     = 4'b0011 << {addr_lo[1], 1'b0};
            wdata_rep = {2{wdata[15:0]}};
         end
         SW: begin
            wstrb     = 4'b1111;
            wdata_rep = wdata;
         end
         default: begin
            wstrb     = 4'b0000;
            wdata_rep = wdata;
         end
      endcase
   end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one outstanding data-memory access, IDLE -> WAIT -> DONE handshake.
// Define LSU_MISALIGN_TRAP_EN to fault on misaligned half/word accesses instead of truncating.
module lsu
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 32
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              dmem_read,
   input  logic              dmem_write,
   input  logic [2:0]        funct3,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_wstrb,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ack,
   input  logic [31:0]       mem_rdata,
   output logic [31:0]       load_data,
   output logic              load_valid,
   output logic              stall,
   output logic              fault
);

   lsu_state_t  state;
   logic [2:0]  funct3_q;
   logic [1:0]  addr_lo_q;
   logic        store_q;
   logic        req_any;
   logic        trap;
   logic [2:0]  align_f3;
   logic [1:0]  align_lo;
   logic [31:0] load_ext;
   logic [3:0]  strb;
   logic [31:0] wdata_rep;

   assign req_any = dmem_read | dmem_write;

`ifdef LSU_MISALIGN_TRAP_EN
   assign trap = misaligned(dmem_write, funct3, addr[1:0]);
`else
   assign trap = 1'b0;
`endif

   // In IDLE the aligner shapes the incoming store; afterwards it decodes the returning load.
   assign align_f3 = (state == IDLE) ? funct3    : funct3_q;
   assign align_lo = (state == IDLE) ? addr[1:0] : addr_lo_q;

   lsu_align u_align (
      .funct3    (align_f3),
      .addr_lo   (align_lo),
      .rdata     (mem_rdata),
      .wdata     (wdata),
      .load_ext  (load_ext),
      .wstrb     (strb),
      .wdata_rep (wdata_rep)
   );

   assign stall = (state == WAIT) || ((state == IDLE) && req_any && !trap);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         funct3_q   <= 3'd0;
         addr_lo_q  <= 2'd0;
         store_q    <= 1'b0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wstrb  <= 4'd0;
         mem_wdata  <= 32'd0;
         load_data  <= 32'd0;
         load_valid <= 1'b0;
         fault      <= 1'b0;
      end else begin
         load_valid <= 1'b0;
         fault      <= 1'b0;
         case (state)
            IDLE: begin
               if (req_any) begin
                  if (trap) begin
                     fault <= 1'b1;
                  end else begin
                     state     <= WAIT;
                     mem_req   <= 1'b1;
                     mem_we    <= dmem_write;
                     store_q   <= dmem_write;
                     funct3_q  <= funct3;
                     addr_lo_q <= addr[1:0];
                     mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
                     mem_wstrb <= dmem_write ? strb : 4'b0000;
                     mem_wdata <= wdata_rep;
                  end
               end
            end
            WAIT: begin
               if (mem_ack) begin
                  state     <= DONE;
                  mem_req   <= 1'b0;
                  mem_we    <= 1'b0;
                  mem_wstrb <= 4'b0000;
                  if (!store_q) begin
                     load_data  <= load_ext;
                     load_valid <= 1'b1;
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
